// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared types and constants for the fetch sequencer slice.
//   fetch_state_t : sequencer FSM states (request / wait for response / hold)
//   NOP_INSTR     : instruction word shown in empty slots (addi x0,x0,0)
//   FETCH_WIDTH   : instructions per fetch group
//   GROUP_BYTES   : byte stride between consecutive fetch groups
// -----------------------------------------------------------------------------
package fetch_pkg;

  typedef enum logic [1:0] {
    FS_REQ  = 2'd0,
    FS_WAIT = 2'd1,
    FS_HOLD = 2'd2
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;
  localparam int          FETCH_WIDTH = 3;
  localparam int          GROUP_BYTES = 12;

endpackage

// File: rtl/fetch_sequencer_if.sv
// -----------------------------------------------------------------------------
// fetch_sequencer_if
// Bundles the instruction-memory request/response channel and the fetch-group
// outputs towards the instruction buffer.
//   master : the fetch sequencer (drives requests and fetch slots)
//   slave  : the environment (memory + instruction buffer)
// Signals:
//   imem_req_valid_o / imem_req_ready_i / imem_req_addr_o : request channel
//   imem_rsp_valid_i / imem_rsp_data_i                    : response channel
//   fetch_valid_o, instruction_o_k, pc_o_k, fetch_ready_i : buffer side
// -----------------------------------------------------------------------------
interface fetch_sequencer_if #(
  parameter int DATA_WIDTH = 32
);

  logic                    imem_req_valid_o;
  logic                    imem_req_ready_i;
  logic [DATA_WIDTH-1:0]   imem_req_addr_o;
  logic                    imem_rsp_valid_i;
  logic [3*DATA_WIDTH-1:0] imem_rsp_data_i;
  logic [2:0]              fetch_valid_o;
  logic [DATA_WIDTH-1:0]   instruction_o_0;
  logic [DATA_WIDTH-1:0]   instruction_o_1;
  logic [DATA_WIDTH-1:0]   instruction_o_2;
  logic [DATA_WIDTH-1:0]   pc_o_0;
  logic [DATA_WIDTH-1:0]   pc_o_1;
  logic [DATA_WIDTH-1:0]   pc_o_2;
  logic                    fetch_ready_i;

  modport master (
    output imem_req_valid_o,
    output imem_req_addr_o,
    input  imem_req_ready_i,
    input  imem_rsp_valid_i,
    input  imem_rsp_data_i,
    output fetch_valid_o,
    output instruction_o_0,
    output instruction_o_1,
    output instruction_o_2,
    output pc_o_0,
    output pc_o_1,
    output pc_o_2,
    input  fetch_ready_i
  );

  modport slave (
    input  imem_req_valid_o,
    input  imem_req_addr_o,
    output imem_req_ready_i,
    output imem_rsp_valid_i,
    output imem_rsp_data_i,
    input  fetch_valid_o,
    input  instruction_o_0,
    input  instruction_o_1,
    input  instruction_o_2,
    input  pc_o_0,
    input  pc_o_1,
    input  pc_o_2,
    output fetch_ready_i
  );

endinterface

// File: rtl/fetch_group_reg.sv
// -----------------------------------------------------------------------------
// fetch_group_reg
// Holding register for one fetch group (SLOTS instructions plus their PCs).
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   load       : capture load_data; slot k gets PC load_base + 4k
//   clear      : invalidate all slots (NOP, PC 0); wins over load
//   load_base  : byte address of slot 0
//   load_data  : slot k in bits [k*DATA_WIDTH +: DATA_WIDTH]
//   valid_o    : per-slot valid
//   instr_o    : per-slot instruction
//   pc_o       : per-slot PC
// With neither load nor clear the contents are held unchanged.
// -----------------------------------------------------------------------------
module fetch_group_reg
  import fetch_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int SLOTS      = 3
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 load,
  input  logic                                 clear,
  input  logic [DATA_WIDTH-1:0]                load_base,
  input  logic [SLOTS*DATA_WIDTH-1:0]          load_data,
  output logic [SLOTS-1:0]                     valid_o,
  output logic [SLOTS-1:0][DATA_WIDTH-1:0]     instr_o,
  output logic [SLOTS-1:0][DATA_WIDTH-1:0]     pc_o
);

  logic [SLOTS-1:0]                 valid_reg;
  logic [SLOTS-1:0][DATA_WIDTH-1:0] instr_reg;
  logic [SLOTS-1:0][DATA_WIDTH-1:0] pc_reg;

  genvar gi;
  generate
    for (gi = 0; gi < SLOTS; gi++) begin : g_slot
      always_ff @(posedge clk) begin
        if (reset || clear) begin
          valid_reg[gi] <= 1'b0;
          instr_reg[gi] <= DATA_WIDTH'(NOP_INSTR);
          pc_reg[gi]    <= '0;
        end else if (load) begin
          valid_reg[gi] <= 1'b1;
          instr_reg[gi] <= load_data[gi*DATA_WIDTH +: DATA_WIDTH];
          // Slot PCs wrap naturally at the top of the address space.
          pc_reg[gi]    <= load_base + DATA_WIDTH'(4 * gi);
        end
      end
    end
  endgenerate

  assign valid_o = valid_reg;
  assign instr_o = instr_reg;
  assign pc_o    = pc_reg;

endmodule

// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
// Fetch-side controller for the instruction buffer. Issues one instruction
// memory request per 3-instruction group, holds the returned group until the
// buffer takes it, and handles branch redirects (flush + discard of a stale
// in-flight response).
// Ports:
//   clk, reset       : clock and synchronous active-high reset
//   bus (master)     : imem request/response channel and fetch-group outputs
//   redirect_valid_i : redirect request (priority over everything but reset)
//   redirect_pc_i    : new fetch PC (low 2 bits ignored)
//   flush_o          : combinational flush to the buffer, equals redirect_valid_i
//   group_count_o    : groups delivered to the buffer (wrapping)
//   stall_count_o    : cycles a group was held with fetch_ready_i low (wrapping)
// At most one request is outstanding; responses arrive in order.
// -----------------------------------------------------------------------------
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int                    DATA_WIDTH  = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC    = '0,
  parameter int                    FETCH_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  fetch_sequencer_if.master     bus,
  input  logic                  redirect_valid_i,
  input  logic [DATA_WIDTH-1:0] redirect_pc_i,
  output logic                  flush_o,
  output logic [31:0]           group_count_o,
  output logic [31:0]           stall_count_o
);

  localparam logic [DATA_WIDTH-1:0] ALIGN_MASK = ~DATA_WIDTH'(3);
  localparam logic [DATA_WIDTH-1:0] GROUP_STEP = DATA_WIDTH'(GROUP_BYTES);

  fetch_state_t          state_reg, state_next;
  logic [DATA_WIDTH-1:0] pc_reg, pc_next;
  logic [DATA_WIDTH-1:0] req_addr_reg, req_addr_next;
  logic                  discard_reg, discard_next;
  logic [31:0]           group_count_reg, group_count_next;
  logic [31:0]           stall_count_reg, stall_count_next;

  logic                  req_fire;
  logic                  grp_load;
  logic                  grp_clear;

  logic [FETCH_WIDTH-1:0]                 grp_valid;
  logic [FETCH_WIDTH-1:0][DATA_WIDTH-1:0] grp_instr;
  logic [FETCH_WIDTH-1:0][DATA_WIDTH-1:0] grp_pc;

  assign req_fire = (state_reg == FS_REQ) && bus.imem_req_ready_i;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= FS_REQ;
      pc_reg          <= RESET_PC & ALIGN_MASK;
      req_addr_reg    <= '0;
      discard_reg     <= 1'b0;
      group_count_reg <= '0;
      stall_count_reg <= '0;
    end else begin
      state_reg       <= state_next;
      pc_reg          <= pc_next;
      req_addr_reg    <= req_addr_next;
      discard_reg     <= discard_next;
      group_count_reg <= group_count_next;
      stall_count_reg <= stall_count_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic. Normal flow first, then the redirect overlay which
  // replaces the decisions of the normal flow where it applies.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next       = state_reg;
    pc_next          = pc_reg;
    req_addr_next    = req_addr_reg;
    discard_next     = discard_reg;
    group_count_next = group_count_reg;
    stall_count_next = stall_count_reg;
    grp_load         = 1'b0;
    grp_clear        = 1'b0;

    case (state_reg)
      FS_REQ: begin
        if (req_fire) begin
          req_addr_next = pc_reg;
          pc_next       = pc_reg + GROUP_STEP;
          state_next    = FS_WAIT;
        end
      end
      FS_WAIT: begin
        if (bus.imem_rsp_valid_i) begin
          if (discard_reg) begin
            // Stale response from before a redirect: drop and re-request.
            discard_next = 1'b0;
            state_next   = FS_REQ;
          end else begin
            grp_load   = 1'b1;
            state_next = FS_HOLD;
          end
        end
      end
      FS_HOLD: begin
        if (bus.fetch_ready_i) begin
          grp_clear        = 1'b1;
          group_count_next = group_count_reg + 32'd1;
          state_next       = FS_REQ;
        end else begin
          stall_count_next = stall_count_reg + 32'd1;
        end
      end
      default: begin
        state_next = FS_REQ;
      end
    endcase

    if (redirect_valid_i) begin
      // The held group (if any) is invalidated and no transfer or stall is
      // accounted for in a redirect cycle.
      pc_next          = redirect_pc_i & ALIGN_MASK;
      grp_load         = 1'b0;
      grp_clear        = 1'b1;
      group_count_next = group_count_reg;
      stall_count_next = stall_count_reg;

      case (state_reg)
        FS_REQ: begin
          if (req_fire) begin
            // The request just left; its response must be thrown away.
            discard_next = 1'b1;
            state_next   = FS_WAIT;
          end else begin
            state_next = FS_REQ;
          end
        end
        FS_WAIT: begin
          if (bus.imem_rsp_valid_i) begin
            // The only outstanding response is consumed right now, so
            // nothing remains in flight to discard.
            discard_next = 1'b0;
            state_next   = FS_REQ;
          end else begin
            discard_next = 1'b1;
            state_next   = FS_WAIT;
          end
        end
        default: begin
          state_next = FS_REQ;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Group holding register
  // ---------------------------------------------------------------------------
  fetch_group_reg #(
    .DATA_WIDTH (DATA_WIDTH),
    .SLOTS      (FETCH_WIDTH)
  ) u_group (
    .clk       (clk),
    .reset     (reset),
    .load      (grp_load),
    .clear     (grp_clear),
    .load_base (req_addr_reg),
    .load_data (bus.imem_rsp_data_i),
    .valid_o   (grp_valid),
    .instr_o   (grp_instr),
    .pc_o      (grp_pc)
  );

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.imem_req_valid_o = (state_reg == FS_REQ);
  assign bus.imem_req_addr_o  = pc_reg;
  assign bus.fetch_valid_o    = grp_valid;
  assign bus.instruction_o_0  = grp_instr[0];
  assign bus.instruction_o_1  = grp_instr[1];
  assign bus.instruction_o_2  = grp_instr[2];
  assign bus.pc_o_0           = grp_pc[0];
  assign bus.pc_o_1           = grp_pc[1];
  assign bus.pc_o_2           = grp_pc[2];

  assign flush_o       = redirect_valid_i;
  assign group_count_o = group_count_reg;
  assign stall_count_o = stall_count_reg;

endmodule
